// File: rtl/data_out_capture.sv
// data_out_capture: captures datapath result words into a small history
// buffer on rising edges of a capture request. A switch-selected entry and
// the capture bookkeeping are shown on the board LEDs and seven-segment digits.
module data_out_capture #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] datapath_out,
  input  logic        status,
  input  logic        capture,
  input  logic        clear,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  // Pointer width covers DEPTH entries; count needs one more bit to reach DEPTH.
  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FROZEN   = 2'd1;
  localparam logic [1:0] CLEARING = 2'd2;

  // Count of stored entries, held at DEPTH once the buffer is full.
  function automatic logic [CW-1:0] sat_inc_count(input logic [CW-1:0] c);
    if (c == CW'(DEPTH)) begin
      return c;
    end
    return c + CW'(1);
  endfunction

  // Dropped-capture counter, held at 15 once it tops out.
  function automatic logic [3:0] sat_inc_drop(input logic [3:0] d);
    if (d == 4'hF) begin
      return d;
    end
    return d + 4'h1;
  endfunction

  // Count shown on four LEDs: zero-extend small counts, drop the top bit of a
  // full 16-entry count (the overflow LED still tells the full story).
  function automatic logic [3:0] fit4(input logic [CW-1:0] c);
    logic [7:0] wide;
    wide = {{(8-CW){1'b0}}, c};
    return wide[3:0];
  endfunction

  // Active-low seven-segment pattern, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          cap_prev;
  logic          cap_armed;
  logic          cap_evt;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [3:0]    dropped;
  logic          overflow;
  logic [16:0]   buffer [DEPTH];

  logic [AW-1:0] age_p0;
  logic [AW-1:0] sel_idx_p0;
  logic [16:0]   sel_entry_p0;

  // Switch bits outside the view/freeze/age fields carry no function here.
  logic unused_sw;
  assign unused_sw = ^SW[7:0];

  // Track the previous capture level; stay disarmed after reset until capture
  // has been seen low, so a level held through reset release is not an event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_prev  <= 1'b0;
      cap_armed <= 1'b0;
    end else begin
      cap_prev <= capture;
      if (!capture) begin
        cap_armed <= 1'b1;
      end
    end
  end

  assign cap_evt = capture & ~cap_prev & cap_armed;

  // Next mode: clear wins from any state; CLEARING lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = CLEARING;
    end else begin
      case (state)
        RUN:      state_nxt = SW[8] ? FROZEN : RUN;
        FROZEN:   state_nxt = SW[8] ? FROZEN : RUN;
        CLEARING: state_nxt = SW[8] ? FROZEN : RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // Mode register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // History buffer and bookkeeping: store in RUN, count drops in FROZEN,
  // wipe everything in CLEARING. A clear request swallows a same-cycle event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
      wr_ptr   <= '0;
      count    <= '0;
      dropped  <= '0;
      overflow <= 1'b0;
    end else if (state == CLEARING) begin
      for (int i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
      wr_ptr   <= '0;
      count    <= '0;
      dropped  <= '0;
      overflow <= 1'b0;
    end else if (!clear && cap_evt) begin
      if (state == RUN) begin
        buffer[wr_ptr] <= {status, datapath_out};
        wr_ptr         <= wr_ptr + AW'(1);
        count          <= sat_inc_count(count);
        if (count == CW'(DEPTH)) begin
          overflow <= 1'b1;
        end
      end else if (state == FROZEN) begin
        dropped <= sat_inc_drop(dropped);
      end
    end
  end

  // Stage p0: pick the entry 'age' captures back from the newest; entries
  // older than what has been stored read as zero.
  always_comb begin
    age_p0       = SW[AW-1:0];
    sel_idx_p0   = wr_ptr - AW'(1) - age_p0;
    sel_entry_p0 = buffer[sel_idx_p0];
    if ({1'b0, age_p0} >= count) begin
      sel_entry_p0 = '0;
    end
  end

  // Stage p1: registered LED and seven-segment outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      LEDR <= '0;
      HEX0 <= 7'b1000000;
      HEX1 <= 7'b1000000;
      HEX2 <= 7'b1000000;
      HEX3 <= 7'b1000000;
    end else begin
      if (SW[9]) begin
        LEDR <= {overflow, (state == FROZEN), dropped, fit4(count)};
      end else begin
        LEDR <= {overflow, sel_entry_p0[16], sel_entry_p0[7:0]};
      end
      HEX0 <= seg7(sel_entry_p0[3:0]);
      HEX1 <= seg7(sel_entry_p0[7:4]);
      HEX2 <= seg7(sel_entry_p0[11:8]);
      HEX3 <= seg7(sel_entry_p0[15:12]);
    end
  end

endmodule

// File: tb/tb_data_out_capture.sv
// Directed bench for data_out_capture with DEPTH=4.
module tb_data_out_capture;

  logic        clk;
  logic        resetn;
  logic [15:0] datapath_out;
  logic        status;
  logic        capture;
  logic        clear;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;

  int n_assert = 0;
  int n_fail   = 0;

  data_out_capture #(.DEPTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .datapath_out (datapath_out),
    .status       (status),
    .capture      (capture),
    .clear        (clear),
    .SW           (SW),
    .LEDR         (LEDR),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .HEX3         (HEX3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] hexword(input logic [15:0] d);
    return {seg(d[15:12]), seg(d[11:8]), seg(d[7:4]), seg(d[3:0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] data, input logic [9:0] ledr);
    check({tag, " HEX"}, {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, hexword(data)});
    check({tag, " LEDR"}, {22'h0, LEDR}, {22'h0, ledr});
  endtask

  initial begin
    resetn       = 1'b1;
    datapath_out = 16'h0;
    status       = 1'b0;
    capture      = 1'b0;
    clear        = 1'b0;
    SW           = 10'h000;

    // Asynchronous reset before any clock edge.
    #2 resetn = 1'b0;
    #1;
    chk_disp("reset", 16'h0000, 10'h000);
    tick();
    resetn = 1'b1;
    tick();
    tick();
    chk_disp("post_reset", 16'h0000, 10'h000);

    // Two captures, newest and one-back.
    datapath_out = 16'h1234; status = 1'b0; pulse();
    datapath_out = 16'hABCD; status = 1'b1; pulse();
    chk_disp("age0_abcd", 16'hABCD, 10'h1CD);
    SW = 10'h001; tick();
    chk_disp("age1_1234", 16'h1234, 10'h034);
    SW = 10'h200; tick();
    chk_disp("view_count2", 16'hABCD, 10'h002);

    // Clear, then overfill a 4-deep buffer.
    SW = 10'h000;
    clear = 1'b1; tick();
    clear = 1'b0; tick();
    tick();
    chk_disp("cleared", 16'h0000, 10'h000);
    status = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      datapath_out = 16'(v);
      pulse();
    end
    chk_disp("ovf_age0", 16'h0005, 10'h205);
    SW = 10'h001; tick();
    chk_disp("ovf_age1", 16'h0004, 10'h204);
    SW = 10'h002; tick();
    chk_disp("ovf_age2", 16'h0003, 10'h203);
    SW = 10'h003; tick();
    chk_disp("ovf_age3", 16'h0002, 10'h202);
    SW = 10'h004; tick();
    chk_disp("age_wrap", 16'h0005, 10'h205);
    SW = 10'h200; tick();
    chk_disp("ovf_view", 16'h0005, 10'h204);

    // Freeze: captures are dropped, buffer untouched.
    SW = 10'h100; tick();
    datapath_out = 16'h00FF;
    repeat (3) pulse();
    SW = 10'h300; tick();
    chk_disp("frozen_view", 16'h0005, 10'h334);
    SW = 10'h000; tick();
    chk_disp("unfreeze_data", 16'h0005, 10'h205);
    SW = 10'h200; tick();
    chk_disp("run_view", 16'h0005, 10'h234);

    // Capture and clear in the same cycle.
    datapath_out = 16'h7777;
    capture = 1'b1; clear = 1'b1; tick();
    capture = 1'b0; clear = 1'b0; tick();
    tick();
    chk_disp("clr_cap_view", 16'h0000, 10'h000);
    SW = 10'h000; tick();
    chk_disp("clr_cap_data", 16'h0000, 10'h000);
    datapath_out = 16'h0042; status = 1'b1; pulse();
    chk_disp("first_after_clr", 16'h0042, 10'h142);
    SW = 10'h001; tick();
    chk_disp("age_ge_count", 16'h0000, 10'h000);

    // Held capture level yields one entry.
    SW = 10'h000;
    datapath_out = 16'h1111; status = 1'b0;
    capture = 1'b1; tick();
    datapath_out = 16'h2222;
    repeat (9) tick();
    capture = 1'b0; tick();
    SW = 10'h200; tick();
    chk_disp("held_count", 16'h1111, 10'h002);
    SW = 10'h000; tick();
    chk_disp("held_age0", 16'h1111, 10'h011);
    SW = 10'h001; tick();
    chk_disp("held_age1", 16'h0042, 10'h142);

    // Third entry, then asynchronous reset between edges.
    SW = 10'h000;
    datapath_out = 16'h0333; status = 1'b0; pulse();
    chk_disp("three_stored", 16'h0333, 10'h033);
    #2 resetn = 1'b0;
    #1;
    chk_disp("async_reset", 16'h0000, 10'h000);
    capture = 1'b1;
    SW = 10'h200;
    tick();
    tick();
    #2 resetn = 1'b1;
    tick();
    tick();
    tick();
    chk_disp("held_thru_reset", 16'h0000, 10'h000);
    SW = 10'h000; tick();
    chk_disp("after_reset_age0", 16'h0000, 10'h000);
    capture = 1'b0; tick();
    datapath_out = 16'h5A5A; status = 1'b0; pulse();
    chk_disp("first_post_reset", 16'h5A5A, 10'h05A);
    SW = 10'h200; tick();
    chk_disp("post_reset_count", 16'h5A5A, 10'h001);

    // Dropped counter saturates at 15.
    SW = 10'h300; tick();
    repeat (17) pulse();
    chk_disp("drop_sat", 16'h5A5A, 10'h1F1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_out_capture.md
DATA_OUT_CAPTURE -- requirements
Module: data_out_capture

Interface
REQ-001 Parameter: DEPTH, 4, number of history entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 resetn  in  1  reset; asynchronous and active-low.
REQ-004 datapath_out  in  16  datapath result word to be captured.
REQ-005 status  in  1  datapath status (Z) flag, captured alongside datapath_out.
REQ-006 capture  in  1  capture request level; only rising edges SHALL count.
REQ-007 clear  in  1  synchronous clear of history, counters and flags.
REQ-008 SW  in  10  board switches: SW[9] view mode, SW[8] freeze, SW[3:0] entry age.
REQ-009 LEDR  out  10  registered status/data LEDs.
REQ-010 HEX0, HEX1, HEX2, HEX3  out  7 each  registered, active-low seven-segment digits; HEX0 is the least-significant nibble.

Function
REQ-011 Edge detect: a capture event SHALL occur on a cycle where capture=1 and the registered previous capture=0.
REQ-012 The state machine SHALL have three states: RUN, FROZEN, CLEARING.
REQ-013 RUN->FROZEN when SW[8]=1; FROZEN->RUN when SW[8]=0; any state->CLEARING when clear=1; CLEARING->RUN after exactly 1 cycle, or ->FROZEN if SW[8]=1.
REQ-014 Capture in RUN: {status, datapath_out} SHALL be written at the event edge to buffer[wr_ptr].
- wr_ptr SHALL increment modulo DEPTH.
- count SHALL increment, saturating at DEPTH.
REQ-015 Capture when count=DEPTH: the oldest entry SHALL be overwritten and the sticky overflow flag SHALL be set.
REQ-016 Capture in FROZEN: the buffer SHALL NOT be written; dropped SHALL increment, saturating at 15.
REQ-017 clear=1 SHALL take priority over a simultaneous capture event in the same cycle: the event is discarded, not dropped.
REQ-018 CLEARING SHALL zero wr_ptr, count, dropped, overflow and every buffer entry; capture events during CLEARING SHALL be discarded.
REQ-019 Selection: age = SW[3:0] mod DEPTH; selected index = (wr_ptr - 1 - age) mod DEPTH; age 0 is the newest entry.
REQ-020 If age >= count, the selected entry SHALL read as 17'b0.
REQ-021 When SW[9]=0: LEDR[7:0] = selected data[7:0]; LEDR[8] = selected status; LEDR[9] = overflow.
REQ-022 When SW[9]=1: LEDR[3:0] = count (zero-extended or truncated to 4 bits; DEPTH=16 full shows 0 with LEDR[9] overflow still meaningful); LEDR[7:4] = dropped; LEDR[8] = (state==FROZEN); LEDR[9] = overflow.
REQ-023 HEX3..HEX0 SHALL always show the selected data[15:0] as hex, a through f, active-low (gfedcba; 0 -> 7'b1000000, F -> 7'b0001110).
REQ-024 Latency: outputs SHALL be registered.
- A capture at edge N SHALL be visible on LEDR/HEX after edge N+1.
- A switch change SHALL be visible one edge after it is sampled.
REQ-025 Mode switching between RUN and FROZEN SHALL NOT alter the buffer, wr_ptr or count.

Reset
REQ-026 While resetn=0, all state SHALL be forced asynchronously to: state=RUN, wr_ptr=0, count=0, dropped=0, overflow=0, buffer=0, previous capture=0, LEDR=0, HEX0..HEX3=7'b1000000.
REQ-027 Reset asserted mid-operation SHALL discard all history; the first capture after release SHALL land at index 0.
REQ-028 A capture held high across reset release SHALL NOT be treated as an event until it falls and rises again.

Verification
REQ-029 Capture 16'h1234 with status=0, then 16'hABCD with status=1; SW=0 -> HEX=ABCD, LEDR[8]=1; SW[3:0]=1 -> HEX=1234, LEDR[8]=0.
REQ-030 DEPTH=4, capture 1,2,3,4,5 -> count=4, overflow=1; ages 0..3 show 5,4,3,2; SW[9]=1 -> LEDR[3:0]=4, LEDR[9]=1.
REQ-031 SW[8]=1, pulse capture 3 times with value 16'h00FF -> buffer unchanged, SW[9]=1 shows LEDR[7:4]=3, LEDR[8]=1; release freeze -> state RUN.
REQ-032 Capture and clear asserted in the same cycle -> count=0, dropped=0, HEX=0000 two edges later; the next capture is stored at index 0.
REQ-033 Hold capture=1 for 10 cycles -> exactly one entry is stored.
REQ-034 Assert resetn=0 asynchronously between edges with 3 entries stored -> outputs zero immediately (HEX=0000); after release, SW[3:0]=0 reads 0.
